// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
    typedef enum logic [1:0] {RD, WR, BRD, BWR} op_e;

    localparam logic [1:0] SZ_4 = 2'd0;
    localparam logic [1:0] SZ_1 = 2'd1;
    localparam logic [1:0] SZ_2 = 2'd2;
    localparam logic [1:0] SZ_3 = 2'd3;

    localparam int BLOCK_WORDS = 8;
    localparam int BLOCK_EXTRA = 7;

    // Natural-alignment test for writes and block ops; reads never flag.
    function automatic logic is_misaligned(input op_e op, input logic [1:0] size,
                                           input logic [4:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (op)
            BRD, BWR: bad = (addr_lo[4:2] != 3'd0);
            WR: begin
                case (size)
                    SZ_2:    bad = addr_lo[0];
                    SZ_3:    bad = addr_lo[1];
                    SZ_4:    bad = (addr_lo[1:0] != 2'd0);
                    default: bad = 1'b0;
                endcase
            end
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Big-endian byte-lane merge: places the low N bytes of the write data at
// offsets offset..offset+N-1 of the old word, dropping lanes past offset 3.
module dmem_lane_merge
    import dmem_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] merged_o,
    output logic [3:0]  mask_o
);

    int lane;

    // mask_o[j] covers bits [8j+7:8j]; offset 0 is lane 3.
    always_comb begin
        merged_o = old_word_i;
        mask_o   = 4'h0;
        lane     = 0;
        if (size_i == SZ_4) begin
            merged_o = data_i;
            mask_o   = 4'hF;
        end else begin
            for (int k = 0; k < 4; k++) begin
                lane = int'(offset_i) + k;
                if (k < int'(size_i) && lane < 4) begin
                    merged_o[31-8*lane -: 8] = data_i[8*(int'(size_i)-1-k) +: 8];
                    mask_o[3-lane]           = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for word/partial-word and 256-bit block accesses with
// a programmable-latency Ready_OUT pulse. Optional DMEM_ALIGN_CHECK_EN adds AlignErr_OUT.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic [31:0]  DataAddress_IN,
    input  logic [31:0]  Data_IN,
    input  logic [1:0]   DataSize_IN,
    input  logic         MemRead_IN,
    input  logic         MemWrite_IN,
    input  logic [255:0] DataBlock_IN,
    input  logic         MemBlockRead_IN,
    input  logic         MemBlockWrite_IN,
    output logic [31:0]  Data_OUT,
    output logic [255:0] DataBlock_OUT,
    output logic         Ready_OUT
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic         AlignErr_OUT
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + BLOCK_EXTRA + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    op_e             op_q, op_in;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [1:0]      size_q;
    logic [255:0]    bdata_q;
    logic [31:0]     data_q;
    logic [255:0]    block_q;
    logic            ready_q, ready_d;
    logic            req_any, accept, fire, skip;
    logic            do_rd, do_wr, do_brd, do_bwr;
    logic [AW-1:0]   widx, bbase;
    logic [31:0]     merged;
    logic [3:0]      mask;
    logic            unused_addr;

    logic [31:0]     mem [DEPTH_WORDS];

    assign unused_addr = ^DataAddress_IN[31:AW+2];
    assign req_any     = MemRead_IN | MemWrite_IN | MemBlockRead_IN | MemBlockWrite_IN;
    assign accept      = (state_q == IDLE) && req_any;
    assign widx        = addr_q[AW+1:2];
    assign bbase       = widx & ~AW'(BLOCK_WORDS - 1);

    always_comb begin
        if (MemBlockWrite_IN)     op_in = BWR;
        else if (MemBlockRead_IN) op_in = BRD;
        else if (MemWrite_IN)     op_in = WR;
        else                      op_in = RD;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = BUSY;
                    cnt_d   = (op_in == BRD || op_in == BWR) ? CW'(LATENCY + BLOCK_EXTRA)
                                                             : CW'(LATENCY);
                end
            end
            BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The array access happens on the last BUSY edge, together with Ready_OUT rising.
    always_comb begin
        fire = (state_q == BUSY) && (cnt_q == CW'(1));
`ifdef DMEM_ALIGN_CHECK_EN
        skip = is_misaligned(op_q, size_q, addr_q[4:0]);
`else
        skip = 1'b0;
`endif
        do_rd   = fire && !skip && (op_q == RD);
        do_wr   = fire && !skip && (op_q == WR);
        do_brd  = fire && !skip && (op_q == BRD);
        do_bwr  = fire && !skip && (op_q == BWR);
        ready_d = fire;
    end

    always_ff @(posedge CLOCK) begin
        if (accept) begin
            op_q    <= op_in;
            addr_q  <= DataAddress_IN[AW+1:0];
            wdata_q <= Data_IN;
            size_q  <= DataSize_IN;
            bdata_q <= DataBlock_IN;
        end
    end

    dmem_lane_merge u_merge (
        .old_word_i (mem[widx]),
        .data_i     (wdata_q),
        .size_i     (size_q),
        .offset_i   (addr_q[1:0]),
        .merged_o   (merged),
        .mask_o     (mask)
    );

    always_ff @(posedge CLOCK) begin
        if (do_wr) begin
            for (int j = 0; j < 4; j++) begin
                if (mask[j]) mem[widx][8*j +: 8] <= merged[8*j +: 8];
            end
        end
        if (do_bwr) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                mem[bbase | AW'(i)] <= bdata_q[255-32*i -: 32];
            end
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            data_q  <= '0;
            block_q <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
            if (do_rd) data_q <= mem[widx];
            if (do_brd) begin
                for (int i = 0; i < BLOCK_WORDS; i++) begin
                    block_q[255-32*i -: 32] <= mem[bbase | AW'(i)];
                end
            end
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic aerr_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) aerr_q <= 1'b0;
        else       aerr_q <= fire && skip;
    end

    assign AlignErr_OUT = aerr_q;
`endif

    assign Data_OUT      = data_q;
    assign DataBlock_OUT = block_q;
    assign Ready_OUT     = ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr, wdata;
    logic [1:0]   size;
    logic         rd, wr, brd, bwr;
    logic [255:0] bdata;
    logic [31:0]  dout;
    logic [255:0] bout;
    logic         rdy;
`ifdef DMEM_ALIGN_CHECK_EN
    logic         aerr;
`endif

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .CLOCK            (clk),
        .RESET            (rst),
        .DataAddress_IN   (addr),
        .Data_IN          (wdata),
        .DataSize_IN      (size),
        .MemRead_IN       (rd),
        .MemWrite_IN      (wr),
        .DataBlock_IN     (bdata),
        .MemBlockRead_IN  (brd),
        .MemBlockWrite_IN (bwr),
        .Data_OUT         (dout),
        .DataBlock_OUT    (bout),
        .Ready_OUT        (rdy)
`ifdef DMEM_ALIGN_CHECK_EN
        ,
        .AlignErr_OUT     (aerr)
`endif
    );

    int           total = 0;
    int           bad   = 0;
    logic [31:0]  ref_mem [DEPTH];
    logic [31:0]  exp_data;
    logic [255:0] exp_block;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // kind: 0 read, 1 write, 2 block read, 3 block write
    function automatic bit misaligned(input int kind, input logic [31:0] a, input logic [1:0] sz);
        bit m;
        m = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        if (kind >= 2)             m = (a[4:2] != 3'd0);
        else if (kind == 1) begin
            if (sz == 2'd2)        m = a[0];
            else if (sz == 2'd3)   m = a[1];
            else if (sz == 2'd0)   m = (a[1:0] != 2'd0);
        end
`else
        m = (kind < 0) && (a[0] ^ sz[0]);
`endif
        return m;
    endfunction

    task automatic model_apply(input int kind, input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] sz, input logic [255:0] bd);
        int idx, base, off;
        logic [31:0] w;
        idx  = int'((a >> 2) % DEPTH);
        base = idx - (idx % 8);
        if (misaligned(kind, a, sz)) return;
        case (kind)
            0: exp_data = ref_mem[idx];
            1: begin
                w = ref_mem[idx];
                if (sz == 2'd0) w = d;
                else begin
                    for (int k = 0; k < int'(sz); k++) begin
                        off = int'(a[1:0]) + k;
                        if (off < 4) w[31-8*off -: 8] = d[8*(int'(sz)-1-k) +: 8];
                    end
                end
                ref_mem[idx] = w;
            end
            2: for (int i = 0; i < 8; i++) exp_block[255-32*i -: 32] = ref_mem[base+i];
            default: for (int i = 0; i < 8; i++) ref_mem[base+i] = bd[255-32*i -: 32];
        endcase
    endtask

    task automatic run_op(input bit r, input bit w, input bit br, input bit bw,
                          input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input logic [255:0] bd, input string tag);
        int kind, cycles, exp_lat;
        bit got;
        kind = bw ? 3 : (br ? 2 : (w ? 1 : 0));
        @(negedge clk);
        rd = r; wr = w; brd = br; bwr = bw;
        addr = a; wdata = d; size = sz; bdata = bd;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            got = rdy;
        end
        exp_lat = (kind >= 2) ? LAT + 8 : LAT + 1;
`ifdef DMEM_ALIGN_CHECK_EN
        check({tag, "_aerr"}, aerr, misaligned(kind, a, sz));
`endif
        model_apply(kind, a, d, sz, bd);
        check({tag, "_lat"}, cycles, exp_lat);
        rd = 0; wr = 0; brd = 0; bwr = 0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_pulse"}, rdy, 1'b0);
        check({tag, "_dout"}, dout, exp_data);
        check({tag, "_bout"}, bout, exp_block);
    endtask

    initial begin
        logic [255:0] bd;
        logic [31:0]  prev, a;
        logic [3:0]   reqs;
        bit           seen;

        rst = 1'b1;
        rd = 0; wr = 0; brd = 0; bwr = 0;
        addr = '0; wdata = '0; size = '0; bdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rdy", rdy, 1'b0);
        check("reset_dout", dout, 32'h0);
        check("reset_bout", bout, 256'h0);
`ifdef DMEM_ALIGN_CHECK_EN
        check("reset_aerr", aerr, 1'b0);
`endif
        exp_data  = '0;
        exp_block = '0;
        rst = 1'b0;

        for (int b = 0; b < DEPTH / 8; b++) begin
            for (int i = 0; i < 8; i++) bd[32*i +: 32] = $urandom;
            run_op(0, 0, 0, 1, 32'(b * 32), 32'h0, 2'd0, bd, "init");
        end

        run_op(0, 1, 0, 0, 32'h40, 32'hDEADBEEF, 2'd0, '0, "w_word");
        run_op(1, 0, 0, 0, 32'h40, 32'h0, 2'd0, '0, "r_word");
        check("deadbeef", dout, 32'hDEADBEEF);
        run_op(0, 1, 0, 0, 32'h42, 32'h000000AA, 2'd1, '0, "w_byte");
        run_op(1, 0, 0, 0, 32'h40, 32'h0, 2'd0, '0, "r_byte");
        check("byte_lane", dout, 32'hDEADAAEF);

        bd = {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        run_op(0, 0, 0, 1, 32'h100, 32'h0, 2'd0, bd, "blk_w");
        run_op(0, 0, 1, 0, 32'h11C, 32'h0, 2'd0, '0, "blk_r");
`ifndef DMEM_ALIGN_CHECK_EN
        check("blk_same", bout, bd);
`endif
        run_op(1, 0, 0, 0, 32'h104, 32'h0, 2'd0, '0, "blk_word");
        check("blk_word1", dout, 32'h1);

        prev = dout;
        run_op(1, 1, 0, 0, 32'h48, 32'hCAFEF00D, 2'd0, '0, "wr_rd");
        check("wr_wins_dout", dout, prev);
        run_op(1, 0, 0, 0, 32'h48, 32'h0, 2'd0, '0, "wr_rd_chk");
        check("wr_wins_mem", dout, 32'hCAFEF00D);

        // Reset in the middle of a write: no completion, word untouched, outputs cleared.
        @(negedge clk);
        wr = 1; addr = 32'h80; wdata = 32'h12345678; size = 2'd0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_rdy", rdy, 1'b0);
        check("rst_mid_dout", dout, 32'h0);
        exp_data  = '0;
        exp_block = '0;
        wr = 0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rdy) seen = 1'b1;
        end
        check("rst_no_ready", seen, 1'b0);
        run_op(1, 0, 0, 0, 32'h80, 32'h0, 2'd0, '0, "rst_rd");
        check("rst_unchanged", dout, ref_mem[32]);

`ifdef DMEM_ALIGN_CHECK_EN
        prev = ref_mem[16];
        run_op(0, 1, 0, 0, 32'h41, 32'h11111111, 2'd0, '0, "mis_w");
        run_op(1, 0, 0, 0, 32'h40, 32'h0, 2'd0, '0, "mis_rd");
        check("mis_unchanged", dout, prev);
`endif

        for (int n = 0; n < 200; n++) begin
            reqs = 4'($urandom_range(1, 15));
            a    = $urandom;
            for (int i = 0; i < 8; i++) bd[32*i +: 32] = $urandom;
            run_op(reqs[0], reqs[1], reqs[2], reqs[3], a, $urandom,
                   2'($urandom_range(0, 3)), bd, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
